// File: rtl/button_led_pio.sv
// button_led_pio: Avalon-MM slave for debounced pushbuttons with edge capture
// and maskable interrupt, plus enable-gated per-LED PWM brightness control.
module button_led_pio #(
    parameter int N_BTN           = 4,
    parameter int N_LED           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PWM_BITS        = 8,
    parameter int EDGE_MODE       = 0,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [N_BTN-1:0]  btn_in,
    output logic [N_LED-1:0]  led_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = PWM_BITS'((1 << PWM_BITS) - 2);
    // Pin level of a released button / a dark LED
    localparam logic [N_BTN-1:0]    BTN_REL = {N_BTN{BTN_ACTIVE_LOW != 0}};
    localparam logic [N_LED-1:0]    LED_OFF = {N_LED{LED_ACTIVE_LOW != 0}};

    localparam logic [3:0] A_STATE = 4'd0;
    localparam logic [3:0] A_EDGE  = 4'd1;
    localparam logic [3:0] A_MASK  = 4'd2;
    localparam logic [3:0] A_EN    = 4'd3;

    logic [N_BTN-1:0]    sync_p0, sync_p1;
    logic [N_BTN-1:0]    btn_s;
    logic [N_BTN-1:0]    btn_stable;
    logic [CNT_W-1:0]    db_cnt [N_BTN];
    logic [N_BTN-1:0]    db_done;
    logic [N_BTN-1:0]    edge_set;
    logic [N_BTN-1:0]    edge_w1c;
    logic [N_BTN-1:0]    edge_cap;
    logic [N_BTN-1:0]    irq_mask;
    logic [N_LED-1:0]    led_en;
    logic [PWM_BITS-1:0] duty    [N_LED];
    logic [PWM_BITS-1:0] duty_sh [N_LED];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_LED-1:0]    led_lit;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    // Every writedata bit is consumed only for some parameter sets
    assign unused_wdata = ^writedata;

    // Sampled button level, 1 = pressed
    assign btn_s = sync_p1 ^ BTN_REL;

    // Two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= BTN_REL;
            sync_p1 <= BTN_REL;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // Detect debounce completion, select captured edges and the W1C mask
    always_comb begin
        db_done  = '0;
        edge_set = '0;
        edge_w1c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            db_done[i] = (btn_s[i] != btn_stable[i]) && (db_cnt[i] == DB_LAST);
        end
        case (EDGE_MODE)
            0:       edge_set = db_done & btn_s;
            1:       edge_set = db_done & ~btn_s;
            default: edge_set = db_done;
        endcase
        if (write && address == A_EDGE) begin
            edge_w1c = writedata[N_BTN-1:0];
        end
    end

    // Per-button debounce counters and accepted stable state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_stable <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_s[i] == btn_stable[i] || db_done[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
            btn_stable <= btn_stable ^ db_done;
        end
    end

    // Control/status registers; a fresh edge beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
            irq_mask <= '0;
            led_en   <= '0;
            for (int i = 0; i < N_LED; i++) begin
                duty[i] <= '0;
            end
        end else begin
            edge_cap <= (edge_cap & ~edge_w1c) | edge_set;
            if (write) begin
                if (address == A_MASK) irq_mask <= writedata[N_BTN-1:0];
                if (address == A_EN)   led_en   <= writedata[N_LED-1:0];
                for (int i = 0; i < N_LED; i++) begin
                    if (address == 4'(4 + i)) duty[i] <= writedata[PWM_BITS-1:0];
                end
            end
        end
    end

    // Registered level interrupt from masked captured edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(edge_cap & irq_mask);
    end

    // Read data multiplexer; unmapped addresses and unused bits read 0
    always_comb begin
        rd_mux = '0;
        case (address)
            A_STATE: rd_mux[N_BTN-1:0] = btn_stable;
            A_EDGE:  rd_mux[N_BTN-1:0] = edge_cap;
            A_MASK:  rd_mux[N_BTN-1:0] = irq_mask;
            A_EN:    rd_mux[N_LED-1:0] = led_en;
            default: begin
                for (int i = 0; i < N_LED; i++) begin
                    if (address == 4'(4 + i)) rd_mux[PWM_BITS-1:0] = duty[i];
                end
            end
        endcase
    end

    // One-cycle read latency; a same-cycle write is not yet visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     readdata <= '0;
        else if (read) readdata <= rd_mux;
        else           readdata <= '0;
    end

    // Shared PWM counter and duty shadows reloaded at the end of each period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            for (int i = 0; i < N_LED; i++) begin
                duty_sh[i] <= '0;
            end
        end else if (pwm_cnt == PWM_MAX) begin
            pwm_cnt <= '0;
            for (int i = 0; i < N_LED; i++) begin
                duty_sh[i] <= duty[i];
            end
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Compare counter against each shadow duty
    always_comb begin
        led_lit = '0;
        for (int i = 0; i < N_LED; i++) begin
            led_lit[i] = led_en[i] && (pwm_cnt < duty_sh[i]);
        end
    end

    // Registered LED pins at board polarity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) led_out <= LED_OFF;
        else       led_out <= led_lit ^ LED_OFF;
    end

endmodule
